// File: rtl/qspi_arbiter_if.sv
// Register-port bundle between qspi_arbiter (master) and qspi_core (slave).
// The core returns read data on core_rdata_i the cycle after core_re_o.
interface qspi_arbiter_if;
   logic        core_we_o;
   logic        core_re_o;
   logic [23:0] core_addr_o;
   logic [31:0] core_wdata_o;
   logic [31:0] core_rdata_i;

   modport master (
      output core_we_o,
      output core_re_o,
      output core_addr_o,
      output core_wdata_o,
      input  core_rdata_i
   );

   modport slave (
      input  core_we_o,
      input  core_re_o,
      input  core_addr_o,
      input  core_wdata_o,
      output core_rdata_i
   );
endinterface

// File: rtl/qspi_arbiter.sv
// Two-port flash read arbiter and register sequencer for qspi_core.
// Define QSPI_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module qspi_arbiter #(
   parameter logic [23:0] CTRL_OFF  = 24'd0,
   parameter logic [23:0] ADDR_OFF  = 24'd4,
   parameter logic [23:0] STAT_OFF  = 24'd8,
   parameter logic [23:0] DATA_OFF  = 24'd12,
   parameter logic [23:0] CMD_OFF   = 24'd20,
   parameter logic [31:0] CTRL_WORD = 32'h0F20_8182,
   parameter logic [31:0] CMD_WORD  = 32'h0000_0004,
   parameter int          TIMEOUT   = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req0_i,
   input  logic [23:0]           addr0_i,
   output logic                  ack0_o,
   input  logic                  req1_i,
   input  logic [23:0]           addr1_i,
   output logic                  ack1_o,
   output logic [31:0]           rdata_o,
   output logic                  err_o,
   qspi_arbiter_if.master        core
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WR_CTRL  = 4'd1,
      ST_WR_ADDR  = 4'd2,
      ST_WR_CMD   = 4'd3,
      ST_POLL_RD  = 4'd4,
      ST_POLL_CHK = 4'd5,
      ST_DATA_RD  = 4'd6,
      ST_DATA_CHK = 4'd7,
      ST_RESP     = 4'd8
   } state_e;

   state_e           state_q, state_d;
   logic             port_q, port_d;
   logic [23:0]      faddr_q, faddr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             we_q, we_d;
   logic             re_q, re_d;
   logic [23:0]      caddr_q, caddr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             grant1_s;

`ifdef QSPI_ARB_RR_EN
   logic last_q, last_d;

   // Winner on a tie is the port not served last
   always_comb begin
      grant1_s = 1'b0;
      if (req0_i && req1_i) begin
         grant1_s = ~last_q;
      end else begin
         grant1_s = req1_i;
      end
   end

   // Last-served pointer follows every grant
   always_comb begin
      last_d = last_q;
      if ((state_q == ST_IDLE) && (req0_i || req1_i)) begin
         last_d = grant1_s;
      end else begin
         last_d = last_q;
      end
   end

   // Pointer register, resets to port 1 so port 0 wins the first tie
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: port 1 only when port 0 is idle
   always_comb begin
      grant1_s = 1'b0;
      grant1_s = req1_i & ~req0_i;
   end
`endif

   // Next-state and transaction bookkeeping
   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      faddr_d = faddr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req0_i || req1_i) begin
               port_d  = grant1_s;
               faddr_d = grant1_s ? addr1_i : addr0_i;
               state_d = ST_WR_CTRL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_CTRL: state_d = ST_WR_ADDR;
         ST_WR_ADDR: state_d = ST_WR_CMD;
         ST_WR_CMD: begin
            cnt_d   = '0;
            state_d = ST_POLL_RD;
         end
         ST_POLL_RD: begin
            if (cnt_q != TIMEOUT_C) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
            state_d = ST_POLL_CHK;
         end
         ST_POLL_CHK: begin
            if (core.core_rdata_i[0] == 1'b0) begin
               state_d = ST_DATA_RD;
            end else if (cnt_q < TIMEOUT_C) begin
               state_d = ST_POLL_RD;
            end else begin
               err_d   = 1'b1;
               rdata_d = 32'hDEAD_BEEF;
               state_d = ST_RESP;
            end
         end
         ST_DATA_RD: state_d = ST_DATA_CHK;
         ST_DATA_CHK: begin
            rdata_d = core.core_rdata_i;
            err_d   = 1'b0;
            state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the next state so they are registered yet aligned with it
   always_comb begin
      we_d    = 1'b0;
      re_d    = 1'b0;
      caddr_d = 24'd0;
      wdata_d = 32'd0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      case (state_d)
         ST_WR_CTRL: begin
            we_d    = 1'b1;
            caddr_d = CTRL_OFF;
            wdata_d = CTRL_WORD;
         end
         ST_WR_ADDR: begin
            we_d    = 1'b1;
            caddr_d = ADDR_OFF;
            wdata_d = {8'h00, faddr_d};
         end
         ST_WR_CMD: begin
            we_d    = 1'b1;
            caddr_d = CMD_OFF;
            wdata_d = CMD_WORD;
         end
         ST_POLL_RD: begin
            re_d    = 1'b1;
            caddr_d = STAT_OFF;
         end
         ST_DATA_RD: begin
            re_d    = 1'b1;
            caddr_d = DATA_OFF;
         end
         ST_RESP: begin
            ack0_d = ~port_d;
            ack1_d = port_d;
         end
         default: begin
            we_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         port_q  <= 1'b0;
         faddr_q <= 24'd0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         caddr_q <= 24'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         faddr_q <= faddr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         we_q    <= we_d;
         re_q    <= re_d;
         caddr_q <= caddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign ack0_o            = ack0_q;
   assign ack1_o            = ack1_q;
   assign rdata_o           = rdata_q;
   assign err_o             = err_q;
   assign core.core_we_o    = we_q;
   assign core.core_re_o    = re_q;
   assign core.core_addr_o  = caddr_q;
   assign core.core_wdata_o = wdata_q;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Directed self-checking bench for qspi_arbiter with a small behavioural qspi_core model.
// Arbitration expectations follow QSPI_ARB_RR_EN when it is defined for the build.
module tb_qspi_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [23:0] addr0, addr1;
   logic        ack0, ack1;
   logic [31:0] rdata;
   logic        err;

   int          checks;
   int          errors;
   int          busy_cfg;
   int          poll_idx;
   logic [31:0] data_word;

   qspi_arbiter_if core_if ();

   qspi_arbiter #(.TIMEOUT(4)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req0_i  (req0),
      .addr0_i (addr0),
      .ack0_o  (ack0),
      .req1_i  (req1),
      .addr1_i (addr1),
      .ack1_o  (ack1),
      .rdata_o (rdata),
      .err_o   (err),
      .core    (core_if.master)
   );

`ifdef QSPI_ARB_RR_EN
   localparam logic [3:0] EXP_ORDER = 4'b1010;
`else
   localparam logic [3:0] EXP_ORDER = 4'b0000;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: status busy for the first busy_cfg polls after each command write
   always @(posedge clk) begin
      if (core_if.core_we_o && (core_if.core_addr_o == 24'd20)) begin
         poll_idx <= 0;
      end
      if (core_if.core_re_o) begin
         if (core_if.core_addr_o == 24'd8) begin
            core_if.core_rdata_i <= {31'd0, (poll_idx < busy_cfg)};
            poll_idx <= poll_idx + 1;
         end else begin
            core_if.core_rdata_i <= data_word;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Steps until an ack appears; cyc counts negedges from the request cycle
   task automatic wait_ack(output int cyc, output logic [1:0] acks);
      cyc  = 0;
      acks = 2'b00;
      while ((acks == 2'b00) && (cyc < 200)) begin
         step();
         cyc++;
         acks = {ack1, ack0};
      end
   endtask

   int         cyc;
   logic [1:0] acks;

   initial begin
      checks    = 0;
      errors    = 0;
      busy_cfg  = 0;
      poll_idx  = 0;
      data_word = 32'hCAFE_F00D;
      core_if.core_rdata_i = 32'd0;
      req0 = 1'b0; req1 = 1'b0;
      addr0 = 24'd0; addr1 = 24'd0;
      rst_n = 1'b0;
      step(); step();
      check_eq("rst_ack", {30'd0, ack1, ack0}, 32'd0);
      check_eq("rst_strobe", {30'd0, core_if.core_we_o, core_if.core_re_o}, 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;
      step();

      // Basic read: exact register sequence and 8-cycle latency
      req0 = 1'b1; addr0 = 24'h001234;
      step();
      check_eq("wr_ctrl_we", {31'd0, core_if.core_we_o}, 32'd1);
      check_eq("wr_ctrl_addr", {8'd0, core_if.core_addr_o}, 32'd0);
      check_eq("wr_ctrl_data", core_if.core_wdata_o, 32'h0F20_8182);
      step();
      check_eq("wr_addr_addr", {8'd0, core_if.core_addr_o}, 32'd4);
      check_eq("wr_addr_data", core_if.core_wdata_o, 32'h0000_1234);
      step();
      check_eq("wr_cmd_addr", {8'd0, core_if.core_addr_o}, 32'd20);
      check_eq("wr_cmd_data", core_if.core_wdata_o, 32'h0000_0004);
      step();
      check_eq("poll_strobes", {30'd0, core_if.core_we_o, core_if.core_re_o}, 32'd1);
      check_eq("poll_addr", {8'd0, core_if.core_addr_o}, 32'd8);
      step();
      check_eq("chk_strobes", {30'd0, core_if.core_we_o, core_if.core_re_o}, 32'd0);
      step();
      check_eq("data_rd_addr", {8'd0, core_if.core_addr_o}, 32'd12);
      check_eq("data_rd_re", {31'd0, core_if.core_re_o}, 32'd1);
      step();
      check_eq("pre_ack", {30'd0, ack1, ack0}, 32'd0);
      step();
      check_eq("basic_ack", {30'd0, ack1, ack0}, 32'd1);
      check_eq("basic_rdata", rdata, 32'hCAFE_F00D);
      check_eq("basic_err", {31'd0, err}, 32'd0);
      req0 = 1'b0;
      step();
      check_eq("ack_pulse", {30'd0, ack1, ack0}, 32'd0);

      // Three busy polls
      busy_cfg = 3; data_word = 32'h1357_9BDF; addr0 = 24'hABCDEF;
      req0 = 1'b1;
      wait_ack(cyc, acks);
      check_eq("busy3_lat", cyc, 32'd14);
      check_eq("busy3_port", {30'd0, acks}, 32'd1);
      check_eq("busy3_rdata", rdata, 32'h1357_9BDF);
      check_eq("busy3_err", {31'd0, err}, 32'd0);
      req0 = 1'b0;
      step();

      // Stuck busy hits TIMEOUT=4
      busy_cfg = 100;
      req0 = 1'b1;
      wait_ack(cyc, acks);
      check_eq("tmo_lat", cyc, 32'd12);
      check_eq("tmo_err", {31'd0, err}, 32'd1);
      check_eq("tmo_rdata", rdata, 32'hDEAD_BEEF);
      req0 = 1'b0;
      step();

      // Reset during polling, then the held request restarts
      req0 = 1'b1;
      step(); step(); step(); step();
      check_eq("pre_rst_re", {31'd0, core_if.core_re_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_strobe", {30'd0, core_if.core_we_o, core_if.core_re_o}, 32'd0);
      check_eq("mid_rst_addr", {8'd0, core_if.core_addr_o}, 32'd0);
      check_eq("mid_rst_rdata", rdata, 32'd0);
      check_eq("mid_rst_err", {31'd0, err}, 32'd0);
      busy_cfg = 0; data_word = 32'h0BAD_F00D;
      step();
      rst_n = 1'b1;
      wait_ack(cyc, acks);
      check_eq("restart_lat", cyc, 32'd8);
      check_eq("restart_port", {30'd0, acks}, 32'd1);
      check_eq("restart_rdata", rdata, 32'h0BAD_F00D);
      req0 = 1'b0;
      step();

      // Port 1 arrives mid-transaction and waits for its turn
      addr0 = 24'h000100; addr1 = 24'h000200; data_word = 32'h2222_1111;
      req0 = 1'b1;
      step(); step(); step();
      req1 = 1'b1;
      wait_ack(cyc, acks);
      check_eq("mid_p0_lat", cyc + 3, 32'd8);
      check_eq("mid_p0_port", {30'd0, acks}, 32'd1);
      req0 = 1'b0;
      step();
      check_eq("mid_idle_ack", {30'd0, ack1, ack0}, 32'd0);
      step();
      check_eq("mid_p1_we", {31'd0, core_if.core_we_o}, 32'd1);
      step();
      check_eq("mid_p1_addr", core_if.core_wdata_o, 32'h0000_0200);
      wait_ack(cyc, acks);
      check_eq("mid_p1_lat", cyc + 2, 32'd8);
      check_eq("mid_p1_port", {30'd0, acks}, 32'd2);
      req1 = 1'b0;
      step();

      // Both ports contend for four transactions
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ack(cyc, acks);
         check_eq($sformatf("tie%0d_lat", i), cyc, 32'd8);
         check_eq($sformatf("tie%0d_port", i), {30'd0, acks},
                  EXP_ORDER[i] ? 32'd2 : 32'd1);
         if (acks[1]) begin
            req1 = 1'b0;
            step();
            req1 = 1'b1;
         end else begin
            req0 = 1'b0;
            step();
            req0 = 1'b1;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/qspi_arbiter.md
# qspi_arbiter

Sequencer and two-port arbiter for the `qspi_core` register interface. It accepts 32-bit flash read requests from an instruction-fetch port (port 0) and a data port (port 1), and grants one request at a time. For each granted request it programs the core's control, address and command registers, then polls the status register until the transfer completes. It reads the result word back and returns it with a one-cycle acknowledge. It sits between the SoC fetch/load paths and `qspi_core`, and owns that core's `we_i/re_i/addr_i/wdata_i/rdata_o` port exclusively.

## Interface

Parameters:
- `CTRL_OFF`, default 24'd0: control register offset.
- `ADDR_OFF`, default 24'd4: flash address register offset.
- `STAT_OFF`, default 24'd8: status register offset; bit 0 = busy.
- `DATA_OFF`, default 24'd12: read data register offset.
- `CMD_OFF`, default 24'd20: command/start register offset.
- `CTRL_WORD`, default 32'h0F20_8182: value written to control.
- `CMD_WORD`, default 32'h0000_0004: value written to command (starts the read).
- `TIMEOUT`, default 1024: maximum poll reads before abort; must be ≥1.

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `rst_ni` in 1: asynchronous active-low reset.
- `req0_i` in 1: port 0 request; held until `ack0_o`.
- `addr0_i` in 24: port 0 flash byte address; stable while `req0_i` is high.
- `ack0_o` out 1: port 0 completion pulse.
- `req1_i`, `addr1_i`, `ack1_o`: same as port 0, for port 1.
- `rdata_o` out 32: read data; valid while an ack is high.
- `err_o` out 1: timeout flag; valid while an ack is high.
- `core_we_o` out 1: register write strobe to `qspi_core`.
- `core_re_o` out 1: register read strobe to `qspi_core`.
- `core_addr_o` out 24: register offset.
- `core_wdata_o` out 32: register write data.
- `core_rdata_i` in 32: register read data. Valid the cycle after `core_re_o`.

## Operation

- FSM states: IDLE, WR_CTRL, WR_ADDR, WR_CMD, POLL_RD, POLL_CHK, DATA_RD, DATA_CHK, RESP.
- IDLE: if any request is high, select a winner, latch its address and port id, go to WR_CTRL.
- WR_CTRL: `core_we_o`=1, `core_addr_o`=CTRL_OFF, `core_wdata_o`=CTRL_WORD.
- WR_ADDR: write `{8'h00, latched_addr}` to ADDR_OFF.
- WR_CMD: write CMD_WORD to CMD_OFF; clear poll counter.
- POLL_RD: `core_re_o`=1, `core_addr_o`=STAT_OFF; increment poll counter.
- POLL_CHK: sample `core_rdata_i[0]`.
  - Busy=0: go to DATA_RD.
  - Busy=1 and counter<TIMEOUT: return to POLL_RD.
  - Busy=1 and counter=TIMEOUT: set error, rdata=32'hDEAD_BEEF, go to RESP.
- DATA_RD: `core_re_o`=1, `core_addr_o`=DATA_OFF.
- DATA_CHK: latch `core_rdata_i` into `rdata_o`; error=0; go to RESP.
- RESP: pulse the granted port's ack for one cycle, then go to IDLE.
- Strobes are exclusive: at most one of `core_we_o`/`core_re_o` is high per cycle. Both are 0 in IDLE, *_CHK and RESP.
- Requests arriving mid-transaction wait; there is no preemption.
- The requester must drop `req` on the clock edge that ends its ack cycle. A request still high in IDLE afterwards is treated as a new request.
- Poll counter is 11 bits; it is width-sized to `$clog2(TIMEOUT+1)` and never wraps.

## Timing

- Reset (async, any state): FSM→IDLE. All outputs 0: `ack*`, `err_o`, `rdata_o`, `core_*_o`. RR pointer→port 1 (so port 0 wins first tie).
- IDLE samples a request at cycle N.
- Minimum latency (not busy on first poll): writes in N+1..N+3, status read N+4, check N+5, data read N+6, check N+7, ack high in N+8.
- Each extra busy poll adds 2 cycles.
- Timeout ack: at N+3+2·TIMEOUT+1.
- Back-to-back throughput: a new grant is no earlier than 1 cycle after RESP (IDLE cycle).
- All outputs are registered.

## Configuration

- `QSPI_ARB_RR_EN` defined: round-robin arbitration. On a tie, grant the port not served last. Pointer updates at every grant.
- Not defined: fixed priority, port 0 always wins ties. Pointer logic is removed.
- Single request (no tie): identical behaviour in both modes.

## Test plan

- Reset mid-POLL (rst_ni low for 1 cycle) → all outputs 0 immediately. A held `req0_i` then restarts from WR_CTRL and completes normally.
- `req0_i`=1, `addr0_i`=24'h001234, status busy=0, data 32'hCAFE_F00D:
  - Writes (0,32'h0F208182), (4,32'h00001234), (20,32'h4).
  - `ack0_o` at N+8 with `rdata_o`=32'hCAFEF00D, `err_o`=0.
- Busy held for 3 polls → ack at N+14, correct data.
- Busy stuck, TIMEOUT=4 → ack at N+12, `err_o`=1, `rdata_o`=32'hDEADBEEF.
- Both requests held for 4 transactions:
  - With `QSPI_ARB_RR_EN`: ack order 0,1,0,1.
  - Without it: port 0 starves port 1 while `req0_i` is re-raised in each IDLE.
- `req1_i` raised during a port-0 transaction → no glitch on `ack1_o`. Port 1 is granted in the IDLE cycle following port-0 RESP.
